// File: rtl/gate_sweep_if.sv
// Handshake/result bundle between a sweep controller and its user/GUT harness.
// The master side drives control and the GUT output; the slave side is the controller.
interface gate_sweep_if #(
  parameter int N_IN = 4
);
  logic            start;
  logic            abort;
  logic [1:0]      func_sel;
  logic [N_IN-1:0] vec;
  logic            dut_f;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_cnt;
  logic            fail_valid;
  logic [N_IN-1:0] first_fail_vec;

  modport master (
    output start, abort, func_sel, dut_f,
    input  vec, busy, done, pass, err_cnt, fail_valid, first_fail_vec
  );

  modport slave (
    input  start, abort, func_sel, dut_f,
    output vec, busy, done, pass, err_cnt, fail_valid, first_fail_vec
  );
endinterface

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive sweep of an N_IN-input combinational gate against a reference
// NAND/NOR/AND/OR, reporting mismatch count, first failing vector and pass.
//
// state    | meaning
// ST_IDLE  | waiting for start; results of the last sweep are held
// ST_WAIT  | vec held on the GUT while r_cnt runs 0..SETTLE-1
// ST_CHECK | compare dut_f with the reference, then advance or finish
module gate_sweep_ctrl #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  gate_sweep_if.slave gs
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  localparam logic [3:0]      CNT_LAST = 4'(SETTLE - 1);
  localparam logic [N_IN:0]   ERR_ONE  = 1;
  localparam logic [N_IN:0]   ERR_MAX  = {1'b1, {N_IN{1'b0}}};
  localparam logic [N_IN-1:0] VEC_ONE  = 1;

  state_t          r_state, w_state;
  logic [3:0]      r_cnt, w_cnt;
  logic [1:0]      r_func, w_func;
  logic [N_IN-1:0] r_vec, w_vec;
  logic [N_IN:0]   r_err, w_err;
  logic            r_fail_valid, w_fail_valid;
  logic [N_IN-1:0] r_first, w_first;
  logic            r_pass, w_pass;
  logic            r_busy, w_busy;
  logic            r_done, w_done;
  logic            w_exp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_func       <= '0;
      r_vec        <= '0;
      r_err        <= '0;
      r_fail_valid <= 1'b0;
      r_first      <= '0;
      r_pass       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_cnt        <= w_cnt;
      r_func       <= w_func;
      r_vec        <= w_vec;
      r_err        <= w_err;
      r_fail_valid <= w_fail_valid;
      r_first      <= w_first;
      r_pass       <= w_pass;
      r_busy       <= w_busy;
      r_done       <= w_done;
    end
  end

  always_comb begin
    case (r_func)
      2'd0:    w_exp = ~&r_vec;
      2'd1:    w_exp = ~|r_vec;
      2'd2:    w_exp = &r_vec;
      default: w_exp = |r_vec;
    endcase
  end

  always_comb begin
    w_state      = r_state;
    w_cnt        = r_cnt;
    w_func       = r_func;
    w_vec        = r_vec;
    w_err        = r_err;
    w_fail_valid = r_fail_valid;
    w_first      = r_first;
    w_pass       = r_pass;
    w_busy       = r_busy;
    w_done       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (gs.start) begin
          w_func       = gs.func_sel;
          w_vec        = '0;
          w_cnt        = '0;
          w_err        = '0;
          w_fail_valid = 1'b0;
          w_first      = '0;
          w_pass       = 1'b0;
          w_busy       = 1'b1;
          w_state      = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (gs.abort) begin
          w_state = ST_IDLE;
          w_busy  = 1'b0;
          w_vec   = '0;
          w_pass  = 1'b0;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + 4'd1;
          if (r_cnt == CNT_LAST) w_state = ST_CHECK;
        end
      end

      ST_CHECK: begin
        // abort wins over this cycle's compare, so the check is simply dropped
        if (gs.abort) begin
          w_state = ST_IDLE;
          w_busy  = 1'b0;
          w_vec   = '0;
          w_pass  = 1'b0;
          w_cnt   = '0;
        end else begin
          if (gs.dut_f != w_exp) begin
            if (r_err != ERR_MAX) w_err = r_err + ERR_ONE;
            if (!r_fail_valid) begin
              w_first      = r_vec;
              w_fail_valid = 1'b1;
            end
          end
          if (&r_vec) begin
            w_busy  = 1'b0;
            w_done  = 1'b1;
            w_pass  = (w_err == '0);
            w_vec   = '0;
            w_state = ST_IDLE;
          end else begin
            w_vec   = r_vec + VEC_ONE;
            w_cnt   = '0;
            w_state = ST_WAIT;
          end
        end
      end

      default: begin
        w_state = ST_IDLE;
        w_busy  = 1'b0;
        w_vec   = '0;
      end
    endcase
  end

  assign gs.vec            = r_vec;
  assign gs.busy           = r_busy;
  assign gs.done           = r_done;
  assign gs.pass           = r_pass;
  assign gs.err_cnt        = r_err;
  assign gs.fail_valid     = r_fail_valid;
  assign gs.first_fail_vec = r_first;

endmodule
